// File: rtl/hs_word_sender_pkg.sv
// ---------------------------------------------------------------------------
// hs_word_sender_pkg
//
// Shared definitions for the valid/ready word handshake initiator.
//   - hs_state_t : FSM state encoding (IDLE / PRESENT / RELEASE)
//   - idx_width  : width of an index counter able to hold 0..n-1,
//                  never narrower than one bit
// ---------------------------------------------------------------------------
package hs_word_sender_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESENT = 2'b01,
        RELEASE = 2'b10
    } hs_state_t;

    // ceil(log2(n)), clamped to a minimum of 1 so a counter always exists.
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hs_word_sender.sv
// ---------------------------------------------------------------------------
// hs_word_sender
//
// Initiator end of the valid/ready word handshake. A wide word of
// RATIO*WORD_LENGTH bits is captured on a single-cycle load strobe and sent
// as RATIO narrow words, least-significant word first.
//
// Handshake: a transfer happens on a rising edge where tx_valid=1 and
// tx_ready=1. Once raised, tx_valid stays high and tx_data stays stable until
// that edge. After every transfer tx_valid is held low for at least one
// cycle, because the receiver only re-arms after it has seen valid low, so
// valid is never high on two consecutive words. tx_ready has no effect while
// tx_valid is low.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   load       in   capture strobe, honoured only while busy=0
//   load_data  in   wide word; [WORD_LENGTH-1:0] is sent first
//   busy       out  high while a wide word is in progress
//   done       out  one-cycle pulse after the final narrow word transferred
//   tx_data    out  narrow word to the receiver (registered)
//   tx_valid   out  word presented (registered)
//   tx_ready   in   receiver ready
// ---------------------------------------------------------------------------
module hs_word_sender
    import hs_word_sender_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int RATIO       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [RATIO*WORD_LENGTH-1:0] load_data,
    output logic                         busy,
    output logic                         done,
    output logic [WORD_LENGTH-1:0]       tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready
);

    localparam int WIDE_W = RATIO * WORD_LENGTH;
    localparam int IDX_W  = idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    hs_state_t         state;
    logic [IDX_W-1:0]  idx;
    logic [WIDE_W-1:0] shift_reg;
    logic [WIDE_W-1:0] shift_next;

    // The word after the current one sits in the low bits once shifted.
    assign shift_next = shift_reg >> WORD_LENGTH;

    assign busy = (state != IDLE);
    assign done = (state == RELEASE) && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            shift_reg <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // tx_data keeps the last sent word here; only reset clears it.
                    if (load) begin
                        shift_reg <= load_data;
                        tx_data   <= load_data[WORD_LENGTH-1:0];
                        idx       <= '0;
                        tx_valid  <= 1'b1;
                        state     <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= RELEASE;
                    end
                end

                RELEASE: begin
                    // Valid is low for this whole cycle, which is the
                    // mandatory gap between consecutive words.
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx       <= idx + 1'b1;
                        shift_reg <= shift_next;
                        tx_data   <= shift_next[WORD_LENGTH-1:0];
                        tx_valid  <= 1'b1;
                        state     <= PRESENT;
                    end
                end

                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_word_sender.sv
// ---------------------------------------------------------------------------
// tb_hs_word_sender
//
// Directed bench for hs_word_sender (WORD_LENGTH=8, RATIO=4). Inputs change
// 1 time unit after the rising edge; outputs are observed on the falling
// edge. Cycle 0 of each scenario is the cycle in which load is driven high.
// ---------------------------------------------------------------------------
module tb_hs_word_sender;

    localparam int WL = 8;
    localparam int RT = 4;

    logic             clk;
    logic             reset;
    logic             load;
    logic [RT*WL-1:0] load_data;
    logic             busy;
    logic             done;
    logic [WL-1:0]    tx_data;
    logic             tx_valid;
    logic             tx_ready;

    hs_word_sender #(
        .WORD_LENGTH (WL),
        .RATIO       (RT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .busy      (busy),
        .done      (done),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard + protocol monitor ----------------
    logic [WL-1:0] exp_q[$];
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [WL-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (prev_valid === 1'b1 && prev_ready === 1'b1)
            check("proto_release", 32'(tx_valid), 32'd0);
        if (prev_valid === 1'b1 && prev_ready === 1'b0 && tx_valid === 1'b1)
            check("proto_stable", 32'(tx_data), 32'(prev_data));
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_q.size() == 0)
                check("sb_extra_word", 32'(tx_data), 32'hFFFF_FFFF);
            else
                check("sb_word", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
    end

    // ---------------- driver tasks ----------------
    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [RT*WL-1:0] w);
        for (int i = 0; i < RT; i++) exp_q.push_back(w[i*WL +: WL]);
    endtask

    // Waits for the done pulse, then confirms busy has fallen and every
    // expected word was seen. Leaves the bench at the start of a fresh cycle.
    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else start_cycle();
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        start_cycle();
        @(negedge clk);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        start_cycle();
    endtask

    // ---------------- FIFO receiver model (depth 4) ----------------
    logic [WL-1:0] fifo_q[$];
    logic [WL-1:0] rd_exp[$];

    // ---------------- stimulus ----------------
    initial begin
        int  rd_cnt;
        int  wr_cnt;
        int  loaded;
        bit  armed;
        bit  rd_en;
        logic [RT*WL-1:0] w;

        reset = 1'b1; load = 1'b0; load_data = '0; tx_ready = 1'b0;
        start_cycle();
        start_cycle();
        @(negedge clk);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data",  32'(tx_data),  32'd0);
        start_cycle();
        reset = 1'b0;

        // ---- basic, ready tied high ----
        push_word(32'hDDCC_BBAA);
        load = 1'b1; load_data = 32'hDDCC_BBAA; tx_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", c), 32'(tx_valid), 32'(c >= 1 && c <= 7 && (c % 2) == 1));
            check($sformatf("t1_done_c%0d", c),  32'(done),     32'(c == 8));
            check($sformatf("t1_busy_c%0d", c),  32'(busy),     32'(c >= 1 && c <= 8));
            if (c == 1) check("t1_data_c1", 32'(tx_data), 32'hAA);
            if (c == 7) check("t1_data_c7", 32'(tx_data), 32'hDD);
            start_cycle();
            load = 1'b0;
        end
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // ---- backpressure: ready low cycles 1..5 ----
        push_word(32'h0403_0201);
        load = 1'b1; load_data = 32'h0403_0201; tx_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                check($sformatf("t2_valid_c%0d", c), 32'(tx_valid), 32'd1);
                check($sformatf("t2_data_c%0d", c),  32'(tx_data),  32'h01);
            end
            start_cycle();
            load = 1'b0;
            tx_ready = (c + 1 >= 6);
        end
        wait_done("t2_done", 100);

        // ---- ignored loads (mid-word and on done), then accepted load ----
        push_word(32'h8765_4321);
        push_word(32'h5A6B_7C8D);
        load = 1'b1; load_data = 32'h8765_4321; tx_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 3)  check("t3_busy_c3",  32'(busy),     32'd1);
            if (c == 8)  check("t3_done_c8",  32'(done),     32'd1);
            if (c == 9)  check("t3_busy_c9",  32'(busy),     32'd0);
            if (c == 9)  check("t3_valid_c9", 32'(tx_valid), 32'd0);
            if (c == 10) check("t3_valid_c10", 32'(tx_valid), 32'd1);
            if (c == 10) check("t3_data_c10",  32'(tx_data),  32'h8D);
            start_cycle();
            load = (c + 1 == 3) || (c + 1 == 8) || (c + 1 == 9);
            load_data = (c + 1 == 9) ? 32'h5A6B_7C8D : 32'hFFFF_FFFF;
        end
        load = 1'b0;
        wait_done("t3_done", 100);

        // ---- reset mid-word, with a coincident load ----
        exp_q.push_back(8'hD4);
        exp_q.push_back(8'hC3);
        load = 1'b1; load_data = 32'hA1B2_C3D4; tx_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 5) begin
                check("t4_valid", 32'(tx_valid), 32'd0);
                check("t4_busy",  32'(busy),     32'd0);
                check("t4_done",  32'(done),     32'd0);
                check("t4_data",  32'(tx_data),  32'd0);
            end
            start_cycle();
            reset = (c + 1 == 4);
            load  = (c + 1 == 4);
            load_data = 32'hDEAD_BEEF;
        end
        check("t4_partial_sb", 32'(exp_q.size()), 32'd0);
        push_word(32'h1122_3344);
        load = 1'b1; load_data = 32'h1122_3344;
        @(negedge clk);
        start_cycle();
        load = 1'b0;
        @(negedge clk);
        check("t4_first_word", 32'(tx_data), 32'h44);
        start_cycle();
        wait_done("t4_done", 100);

        // ---- against a depth-4 FIFO with delayed read-out ----
        push_word(32'h1312_1110);
        push_word(32'h1716_1514);
        for (int i = 0; i < 8; i++) rd_exp.push_back(8'(8'h10 + i));
        rd_cnt = 0; wr_cnt = 0; loaded = 0; armed = 1'b1;
        for (int cyc = 0; cyc < 300 && rd_cnt < 8; cyc++) begin
            tx_ready = armed && (fifo_q.size() < 4);
            if (busy === 1'b0 && loaded < 2) begin
                load = 1'b1;
                w = (loaded == 0) ? 32'h1312_1110 : 32'h1716_1514;
                load_data = w;
                loaded++;
            end else begin
                load = 1'b0;
            end
            rd_en = (cyc >= 30);
            @(negedge clk);
            if (cyc == 29) begin
                check("t5_stall_valid", 32'(tx_valid), 32'd1);
                check("t5_stall_ready", 32'(tx_ready), 32'd0);
                check("t5_stall_data",  32'(tx_data),  32'h14);
                check("t5_fifo_full",   32'(fifo_q.size()), 32'd4);
            end
            if (rd_en && fifo_q.size() > 0) begin
                check($sformatf("t5_rd%0d", rd_cnt), 32'(fifo_q.pop_front()), 32'(rd_exp.pop_front()));
                rd_cnt++;
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                fifo_q.push_back(tx_data);
                wr_cnt++;
                armed = 1'b0;
            end else if (tx_valid === 1'b0) begin
                armed = 1'b1;
            end
            start_cycle();
        end
        load = 1'b0;
        check("t5_rd_count", 32'(rd_cnt), 32'd8);
        check("t5_wr_count", 32'(wr_cnt), 32'd8);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) start_cycle();
        check("t5_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
